// File: rtl/wb_stage.sv
// MIPS writeback stage: registers ALU results, waits for load data, extends sub-word loads.
// Optional commit trace ports are enabled with `define WB_TRACE_EN.
module wb_stage #(
   parameter int DATA_W       = 32,
   parameter int REG_AW       = 5,
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic              in_reg_write,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic              in_is_load,
   input  logic [2:0]        in_load_type,
   input  logic [1:0]        in_addr_lo,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              flush,
`ifdef WB_TRACE_EN
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [REG_AW-1:0] debug_wb_rf_wnum,
   output logic [DATA_W-1:0] debug_wb_rf_wdata,
`endif
   output logic              reg_write,
   output logic [REG_AW-1:0] rd,
   output logic [DATA_W-1:0] write_data,
   output logic              adel,
   output logic              bus_err
);

   typedef enum logic {S_IDLE, S_WAIT_DATA} state_t;

   localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [REG_AW-1:0]   r_ld_rd;
   logic [2:0]          r_ld_type;
   logic [1:0]          r_ld_lo;
   logic                r_ld_wr;

   logic                w_accept, w_misaligned, w_timeout, w_capture;
   logic                w_alu_done, w_ld_done;
   logic                w_wen_nxt, w_adel_nxt, w_berr_nxt;
   logic [REG_AW-1:0]   w_rd_nxt;
   logic [DATA_W-1:0]   w_wdata_nxt, w_ld_data;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;

   assign in_ready  = (r_state == S_IDLE) && !flush;
   assign w_accept  = in_valid && in_ready;
   assign w_timeout = (LOAD_TIMEOUT != 0) && (r_cnt == CNT_W'(LOAD_TIMEOUT - 1));

   always_comb begin
      case (in_load_type)
         3'd0, 3'd1: w_misaligned = 1'b0;
         3'd2, 3'd3: w_misaligned = in_addr_lo[0];
         default:    w_misaligned = |in_addr_lo;
      endcase
   end

   assign w_byte = dmem_rdata[{r_ld_lo, 3'b000} +: 8];
   assign w_half = dmem_rdata[{r_ld_lo[1], 4'b0000} +: 16];

   always_comb begin
      case (r_ld_type)
         3'd0:    w_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         3'd1:    w_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
         3'd2:    w_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
         3'd3:    w_ld_data = {{(DATA_W-16){1'b0}}, w_half};
         default: w_ld_data = dmem_rdata;
      endcase
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wen_nxt   = 1'b0;
      w_adel_nxt  = 1'b0;
      w_berr_nxt  = 1'b0;
      w_rd_nxt    = rd;
      w_wdata_nxt = write_data;
      w_capture   = 1'b0;
      w_alu_done  = 1'b0;
      w_ld_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!in_is_load) begin
                  w_wen_nxt   = in_reg_write && (in_rd != '0);
                  w_rd_nxt    = in_rd;
                  w_wdata_nxt = in_alu_result;
                  w_alu_done  = 1'b1;
               end else if (w_misaligned) begin
                  w_adel_nxt  = 1'b1;
               end else begin
                  w_capture   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WAIT_DATA;
               end
            end
         end
         S_WAIT_DATA: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (flush) begin
               w_state_nxt = S_IDLE;
            end else if (dmem_rvalid) begin
               w_wen_nxt   = r_ld_wr && (r_ld_rd != '0);
               w_rd_nxt    = r_ld_rd;
               w_wdata_nxt = w_ld_data;
               w_ld_done   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_berr_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ld_rd    <= '0;
         r_ld_type  <= '0;
         r_ld_lo    <= '0;
         r_ld_wr    <= 1'b0;
         reg_write  <= 1'b0;
         rd         <= '0;
         write_data <= '0;
         adel       <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         reg_write  <= w_wen_nxt;
         rd         <= w_rd_nxt;
         write_data <= w_wdata_nxt;
         adel       <= w_adel_nxt;
         bus_err    <= w_berr_nxt;
         if (w_capture) begin
            r_ld_rd   <= in_rd;
            r_ld_type <= in_load_type;
            r_ld_lo   <= in_addr_lo;
            r_ld_wr   <= in_reg_write;
         end
      end
   end

`ifdef WB_TRACE_EN
   logic [31:0] r_ld_pc;

   // Trace PC follows the committing instruction; loads report the PC captured at accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ld_pc     <= '0;
         debug_wb_pc <= '0;
      end else begin
         if (w_capture)
            r_ld_pc <= in_pc;
         if (w_alu_done)
            debug_wb_pc <= in_pc;
         else if (w_ld_done)
            debug_wb_pc <= r_ld_pc;
      end
   end

   assign debug_wb_rf_wen   = {4{reg_write}};
   assign debug_wb_rf_wnum  = rd;
   assign debug_wb_rf_wdata = write_data;
`else
   logic w_unused_trace;
   assign w_unused_trace = ^{in_pc, w_alu_done, w_ld_done};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected write/adel/bus_err events
// pushed as stimulus is driven and popped as the DUT reports them.
module tb_wb_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int TO = 4;

   localparam logic [2:0] K_WR   = 3'b100;
   localparam logic [2:0] K_ADEL = 3'b010;
   localparam logic [2:0] K_BERR = 3'b001;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_reg_write, in_is_load;
   logic [31:0]   in_pc;
   logic [AW-1:0] in_rd;
   logic [DW-1:0] in_alu_result;
   logic [2:0]    in_load_type;
   logic [1:0]    in_addr_lo;
   logic          dmem_rvalid, flush;
   logic [DW-1:0] dmem_rdata;
   logic          reg_write, adel, bus_err;
   logic [AW-1:0] rd;
   logic [DW-1:0] write_data;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(DW), .REG_AW(AW), .LOAD_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_reg_write(in_reg_write), .in_rd(in_rd), .in_alu_result(in_alu_result),
      .in_is_load(in_is_load), .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .flush(flush),
      .reg_write(reg_write), .rd(rd), .write_data(write_data),
      .adel(adel), .bus_err(bus_err)
   );

   typedef struct {
      logic [2:0]    kind;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ld_model(input logic [2:0] t, input logic [1:0] lo,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = w >> (8 * int'(lo));
      h = w >> (16 * int'(lo[1]));
      case (t)
         3'd0:    return {{24{b[7]}}, b[7:0]};
         3'd1:    return {24'h0, b[7:0]};
         3'd2:    return {{16{h[15]}}, h[15:0]};
         3'd3:    return {16'h0, h[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] t, input logic [1:0] lo);
      if (t == 3'd2 || t == 3'd3) return lo[0];
      if (t >= 3'd4)              return lo != 2'd0;
      return 1'b0;
   endfunction

   // Monitor: every reported event must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset && (reg_write || adel || bus_err)) begin
         check("evt_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("evt_kind", {29'd0, reg_write, adel, bus_err}, {29'd0, mon_e.kind});
            if (mon_e.kind == K_WR) begin
               check("wr_rd", 32'(rd), 32'(mon_e.rd));
               check("wr_data", write_data, mon_e.data);
            end
         end
      end
   end

   task automatic send(input logic ld, input logic [2:0] t, input logic [1:0] lo,
                       input logic [AW-1:0] r, input logic wr, input logic [31:0] alu);
      @(negedge clk);
      in_valid      = 1'b1;
      in_is_load    = ld;
      in_load_type  = t;
      in_addr_lo    = lo;
      in_rd         = r;
      in_reg_write  = wr;
      in_alu_result = alu;
      in_pc         = $urandom;
      dmem_rvalid   = 1'b0;
      flush         = 1'b0;
      #1 check("ready_on_send", 32'(in_ready), 32'd1);
      if (!ld) begin
         if (wr && r != '0) sb.push_back('{K_WR, r, alu});
      end else if (misaligned(t, lo)) begin
         sb.push_back('{K_ADEL, '0, '0});
      end
      @(posedge clk);
   endtask

   // rvalid is sampled on the k-th edge after the accepting edge.
   task automatic finish_load(input int k, input logic [2:0] t, input logic [1:0] lo,
                              input logic [AW-1:0] r, input logic wr, input logic [31:0] w);
      for (int i = 1; i < k; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1 check("ready_in_wait", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = w;
      #1 check("ready_at_rvalid", 32'(in_ready), 32'd0);
      if (wr && r != '0) sb.push_back('{K_WR, r, ld_model(t, lo, w)});
      @(posedge clk);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1 check("ready_after_load", 32'(in_ready), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid    = 1'b0;
         dmem_rvalid = 1'b0;
         flush       = 1'b0;
      end
   endtask

   typedef struct {
      logic [2:0]  t;
      logic [1:0]  lo;
      logic [31:0] w;
      int          k;
   } ld_vec_t;

   ld_vec_t ld_tab[6] = '{
      '{3'd1, 2'd3, 32'hAB00_0000, 1},
      '{3'd2, 2'd0, 32'h1234_F00D, 2},
      '{3'd4, 2'd0, 32'hDEAD_BEEF, 4},
      '{3'd0, 2'd1, 32'h0000_7F00, 1},
      '{3'd6, 2'd0, 32'h8765_4321, 2},
      '{3'd3, 2'd0, 32'h0000_9ABC, 3}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_reg_write = 1'b0; in_rd = '0;
      in_alu_result = '0; in_is_load = 1'b0; in_load_type = '0; in_addr_lo = '0;
      dmem_rvalid = 1'b0; dmem_rdata = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_write_data", write_data, 32'd0);
      check("rst_adel", 32'(adel), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;

      // Back-to-back ALU writes
      send(1'b0, 3'd0, 2'd0, 5'd3, 1'b1, 32'h11);
      send(1'b0, 3'd0, 2'd0, 5'd4, 1'b1, 32'h22);
      idle(2);

      // LB sign-extension, rvalid three cycles after accept
      send(1'b1, 3'd0, 2'd2, 5'd9, 1'b1, 32'h0);
      finish_load(3, 3'd0, 2'd2, 5'd9, 1'b1, 32'h0080_1234);
      check("lb_value", write_data, 32'hFFFF_FF80);

      // LHU upper half, then misaligned LH
      send(1'b1, 3'd3, 2'd2, 5'd8, 1'b1, 32'h0);
      finish_load(2, 3'd3, 2'd2, 5'd8, 1'b1, 32'h8001_FFFF);
      check("lhu_value", write_data, 32'h0000_8001);
      send(1'b1, 3'd2, 2'd1, 5'd5, 1'b1, 32'h0);
      idle(2);

      foreach (ld_tab[i]) begin
         send(1'b1, ld_tab[i].t, ld_tab[i].lo, AW'(16 + i), 1'b1, 32'h0);
         finish_load(ld_tab[i].k, ld_tab[i].t, ld_tab[i].lo, AW'(16 + i), 1'b1, ld_tab[i].w);
      end

      // More misaligned loads, back to back
      send(1'b1, 3'd4, 2'd2, 5'd6, 1'b1, 32'h0);
      send(1'b1, 3'd3, 2'd3, 5'd6, 1'b1, 32'h0);
      send(1'b1, 3'd4, 2'd1, 5'd6, 1'b1, 32'h0);
      idle(2);

      // Writes to r0 and non-writing instructions produce no strobe
      send(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
      send(1'b0, 3'd0, 2'd0, 5'd6, 1'b0, 32'h1234_5678);
      send(1'b1, 3'd4, 2'd0, 5'd0, 1'b1, 32'h0);
      finish_load(2, 3'd4, 2'd0, 5'd0, 1'b1, 32'h5555_AAAA);
      send(1'b1, 3'd4, 2'd0, 5'd7, 1'b0, 32'h0);
      finish_load(1, 3'd4, 2'd0, 5'd7, 1'b0, 32'h1111_2222);

      // Timeout: four WAIT_DATA cycles, then bus_err and back to IDLE
      send(1'b1, 3'd4, 2'd0, 5'd10, 1'b1, 32'h0);
      sb.push_back('{K_BERR, '0, '0});
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1 check("ready_before_timeout", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      #1 check("ready_after_timeout", 32'(in_ready), 32'd1);
      check("bus_err_pulse", 32'(bus_err), 32'd1);
      check("timeout_no_write", 32'(reg_write), 32'd0);
      @(negedge clk);
      #1 check("bus_err_single", 32'(bus_err), 32'd0);

      // Flush in WAIT_DATA with same-edge rvalid; next instruction accepted the following cycle
      send(1'b1, 3'd4, 2'd0, 5'd11, 1'b1, 32'h0);
      @(negedge clk);
      in_valid    = 1'b0;
      flush       = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hCAFE_F00D;
      #1 check("ready_during_flush", 32'(in_ready), 32'd0);
      send(1'b0, 3'd0, 2'd0, 5'd12, 1'b1, 32'h55);

      // Flush in IDLE blocks accept; a registered write survives a later flush
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd13; in_reg_write = 1'b1;
      in_alu_result = 32'h77; flush = 1'b1;
      #1 check("ready_flush_idle", 32'(in_ready), 32'd0);
      idle(1);
      send(1'b0, 3'd0, 2'd0, 5'd14, 1'b1, 32'h99);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b1;
      idle(1);

      // rvalid outside WAIT_DATA is ignored
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h0BAD_0BAD;
      idle(2);

      // Reset while waiting drops the pending load
      send(1'b1, 3'd4, 2'd0, 5'd15, 1'b1, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1 check("midrst_ready", 32'(in_ready), 32'd1);
      check("midrst_reg_write", 32'(reg_write), 32'd0);
      @(negedge clk);
      reset       = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1357_9BDF;
      idle(3);
      check("post_rst_ready", 32'(in_ready), 32'd1);
      check("post_rst_write_data", write_data, 32'd0);

      idle(2);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
